// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encoding, oversampling rate and framing constants.
// Used by the transmitter now and by the oversampling receiver later.
package uart_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } uart_state_e;

    localparam int TICKS_PER_BIT = 16;

    localparam int PAR_NONE = 0;
    localparam int PAR_EVEN = 1;
    localparam int PAR_ODD  = 2;

    localparam int STOP_TICKS_1   = 16;
    localparam int STOP_TICKS_1P5 = 24;
    localparam int STOP_TICKS_2   = 32;

endpackage

// File: rtl/uart_tx.sv
// UART transmitter paced by the shared 16x oversampling tick: start bit, DBIT data bits
// LSB first, optional parity bit, stop period of SB_TICK ticks, then a one-cycle done pulse.
module uart_tx
    import uart_pkg::*;
#(
    parameter int DBIT     = 8,
    parameter int SB_TICK  = STOP_TICKS_1,
    parameter int PAR_MODE = PAR_NONE
) (
    input  logic            i_clk,
    input  logic            i_reset,
    input  logic            i_tx_start,
    input  logic            i_s_tick,
    input  logic [DBIT-1:0] i_din,
    output logic            o_tx,
    output logic            o_tx_done_tick,
    output logic            o_busy
);

    localparam int              NW        = $clog2(DBIT);
    localparam logic [4:0]      BIT_LAST  = 5'(TICKS_PER_BIT - 1);
    localparam logic [4:0]      STOP_LAST = 5'(SB_TICK - 1);
    localparam logic [NW-1:0]   N_LAST    = NW'(DBIT - 1);

    uart_state_e     state_q, state_d;
    logic [4:0]      s_q, s_d;
    logic [NW-1:0]   n_q, n_d;
    logic [DBIT-1:0] b_q, b_d;
    logic            p_q, p_d;
    logic            tx_q, tx_d;

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            state_q <= ST_IDLE;
            s_q     <= '0;
            n_q     <= '0;
            b_q     <= '0;
            p_q     <= 1'b0;
            tx_q    <= 1'b1;
        end else begin
            state_q <= state_d;
            s_q     <= s_d;
            n_q     <= n_d;
            b_q     <= b_d;
            p_q     <= p_d;
            tx_q    <= tx_d;
        end
    end

    // The line level is decided from the current state and registered, so o_tx trails
    // the state by one clock and can never glitch.
    always_comb begin
        state_d        = state_q;
        s_d            = s_q;
        n_d            = n_q;
        b_d            = b_q;
        p_d            = p_q;
        tx_d           = 1'b1;
        o_tx_done_tick = 1'b0;

        case (state_q)
            ST_IDLE: begin
                tx_d = 1'b1;
                if (i_tx_start) begin
                    b_d     = i_din;
                    s_d     = '0;
                    p_d     = 1'b0;
                    state_d = ST_START;
                end
            end
            ST_START: begin
                tx_d = 1'b0;
                if (i_s_tick) begin
                    if (s_q == BIT_LAST) begin
                        s_d     = '0;
                        n_d     = '0;
                        state_d = ST_DATA;
                    end else begin
                        s_d = s_q + 5'd1;
                    end
                end
            end
            ST_DATA: begin
                tx_d = b_q[0];
                if (i_s_tick) begin
                    if (s_q == BIT_LAST) begin
                        s_d = '0;
                        p_d = p_q ^ b_q[0];
                        b_d = b_q >> 1;
                        if (n_q == N_LAST) begin
                            state_d = (PAR_MODE != PAR_NONE) ? ST_PARITY : ST_STOP;
                        end else begin
                            n_d = n_q + NW'(1);
                        end
                    end else begin
                        s_d = s_q + 5'd1;
                    end
                end
            end
            ST_PARITY: begin
                tx_d = (PAR_MODE == PAR_ODD) ? ~p_q : p_q;
                if (i_s_tick) begin
                    if (s_q == BIT_LAST) begin
                        s_d     = '0;
                        state_d = ST_STOP;
                    end else begin
                        s_d = s_q + 5'd1;
                    end
                end
            end
            ST_STOP: begin
                tx_d = 1'b1;
                if (i_s_tick) begin
                    if (s_q == STOP_LAST) begin
                        state_d        = ST_IDLE;
                        o_tx_done_tick = 1'b1;
                    end else begin
                        s_d = s_q + 5'd1;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign o_tx   = tx_q;
    assign o_busy = (state_q != ST_IDLE);

endmodule

// File: tb/tb_uart_tx.sv
// Bench for uart_tx: four instances (no parity, even, odd, 2 stop bits) share one tick
// source; a per-tick line monitor checks each frame against a scoreboard of expected words.
module tb_uart_tx;
    import uart_pkg::*;

    localparam int         NDUT   = 4;
    // Parity mode per instance, two bits each: dut3=none, dut2=odd, dut1=even, dut0=none.
    localparam logic [7:0] PAR_PK = {2'd0, 2'd2, 2'd1, 2'd0};

    typedef struct {
        int         dut;
        logic [7:0] din;
        int         ticks;
        logic       par;
    } vec_t;

    logic            clk = 1'b0;
    logic            rst;
    logic            s_tick;
    logic            tick_en;
    logic [NDUT-1:0] start;
    logic [NDUT-1:0] tx_o;
    logic [NDUT-1:0] done_o;
    logic [NDUT-1:0] busy_o;
    logic [7:0]      din;

    int checks = 0;
    int errors = 0;

    vec_t sb_q[$];

    always #5 clk = ~clk;

    for (genvar gi = 0; gi < NDUT; gi++) begin : g_dut
        uart_tx #(
            .DBIT    (8),
            .SB_TICK ((gi == 3) ? STOP_TICKS_2 : STOP_TICKS_1),
            .PAR_MODE(int'(PAR_PK[gi*2 +: 2]))
        ) u_dut (
            .i_clk         (clk),
            .i_reset       (rst),
            .i_tx_start    (start[gi]),
            .i_s_tick      (s_tick),
            .i_din         (din),
            .o_tx          (tx_o[gi]),
            .o_tx_done_tick(done_o[gi]),
            .o_busy        (busy_o[gi])
        );
    end

    task automatic check(input bit ok, input string name, input int act, input int req);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL %s: got %0d, required %0d", name, act, req);
        end
    endtask

    // Expected line level for tick i of a frame.
    function automatic logic exp_level(input vec_t v, input bit has_par, input int i);
        int bi;
        bi = i / 16;
        if (bi == 0) return 1'b0;
        if (bi <= 8) return v.din[bi-1];
        if (has_par && bi == 9) return v.par;
        return 1'b1;
    endfunction

    // Tick source: one clk-wide pulse every 4 clocks, changed just after the rising edge.
    int tcnt;
    initial begin
        s_tick = 1'b0;
        tcnt   = 0;
        forever begin
            @(posedge clk);
            #1;
            if (tick_en) begin
                tcnt   = (tcnt + 1) % 4;
                s_tick = (tcnt == 0);
            end else begin
                s_tick = 1'b0;
            end
        end
    end

    // Line monitor, sampled on the falling edge: after a tick edge o_tx shows the bit that tick counted.
    vec_t mon_cur [NDUT];
    bit   mon_act [NDUT];
    bit   mon_unexp [NDUT];
    bit   mon_done_ok [NDUT];
    int   mon_idx [NDUT];
    int   mon_bad [NDUT];
    int   mon_first [NDUT];
    int   frames [NDUT];
    int   dones [NDUT];
    logic mon_lvl;
    logic prev_tick = 1'b0;

    initial begin
        for (int k = 0; k < NDUT; k++) begin
            mon_act[k] = 1'b0;
            frames[k]  = 0;
            dones[k]   = 0;
        end
    end

    always @(negedge clk) begin
        for (int k = 0; k < NDUT; k++) begin
            if (rst) begin
                mon_act[k] = 1'b0;
            end else begin
                if (prev_tick) begin
                    if (!mon_act[k] && tx_o[k] == 1'b0) begin
                        mon_act[k]     = 1'b1;
                        mon_idx[k]     = 0;
                        mon_bad[k]     = 0;
                        mon_first[k]   = -1;
                        mon_done_ok[k] = 1'b0;
                        mon_unexp[k]   = 1'b0;
                        if (sb_q.size() > 0 && sb_q[0].dut == k) begin
                            mon_cur[k] = sb_q.pop_front();
                        end else begin
                            mon_unexp[k] = 1'b1;
                            mon_cur[k]   = '{k, 8'h00, 160, 1'b0};
                        end
                    end
                    if (mon_act[k]) begin
                        mon_lvl = exp_level(mon_cur[k], PAR_PK[k*2 +: 2] != 2'd0, mon_idx[k]);
                        if (tx_o[k] !== mon_lvl ||
                            busy_o[k] !== (mon_idx[k] != mon_cur[k].ticks - 1)) begin
                            if (mon_bad[k] == 0) mon_first[k] = mon_idx[k];
                            mon_bad[k]++;
                        end
                        mon_idx[k]++;
                        if (mon_idx[k] == mon_cur[k].ticks) begin
                            mon_act[k] = 1'b0;
                            frames[k]++;
                            check(!mon_unexp[k] && mon_bad[k] == 0 && mon_done_ok[k],
                                  $sformatf("frame dut%0d din=%02h first_bad_tick=%0d done_ok=%0b unexpected=%0b bad_ticks",
                                            k, mon_cur[k].din, mon_first[k], mon_done_ok[k], mon_unexp[k]),
                                  mon_bad[k], 0);
                            $display("frame dut%0d din=%02h ticks=%0d bad_ticks=%0d",
                                     k, mon_cur[k].din, mon_cur[k].ticks, mon_bad[k]);
                        end
                    end
                end
                if (s_tick && done_o[k]) begin
                    dones[k]++;
                    if (mon_act[k] && mon_idx[k] == mon_cur[k].ticks - 1) mon_done_ok[k] = 1'b1;
                    else if (mon_act[k]) mon_bad[k]++;
                end
            end
        end
        prev_tick = s_tick;
    end

    task automatic send(input int k, input logic [7:0] d);
        @(posedge clk);
        #1;
        din      = d;
        start[k] = 1'b1;
        @(posedge clk);
        #1;
        start[k] = 1'b0;
    endtask

    task automatic wait_frames(input int k, input int target, input string name);
        int cyc;
        cyc = 0;
        while (frames[k] < target && cyc < 3000) begin
            @(posedge clk);
            cyc++;
        end
        check(frames[k] >= target, {name, " frames_seen"}, frames[k], target);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: time limit reached, got no summary, required finish");
        $fatal(1, "watchdog");
    end

    vec_t vecs [10];
    int   base;
    int   d0;
    int   gap;
    int   bad;
    int   cyc;
    bit   line_ok;

    initial begin
        vecs[0] = '{0, 8'hA5, 160, 1'b0};
        vecs[1] = '{0, 8'h00, 160, 1'b0};
        vecs[2] = '{0, 8'hFF, 160, 1'b0};
        vecs[3] = '{1, 8'h07, 176, 1'b1};
        vecs[4] = '{2, 8'h07, 176, 1'b0};
        vecs[5] = '{1, 8'h3C, 176, 1'b0};
        vecs[6] = '{2, 8'h3C, 176, 1'b1};
        vecs[7] = '{2, 8'h80, 176, 1'b0};
        vecs[8] = '{1, 8'h00, 176, 1'b0};
        vecs[9] = '{3, 8'h5A, 176, 1'b0};

        rst     = 1'b1;
        start   = '0;
        din     = '0;
        tick_en = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        for (int k = 0; k < NDUT; k++) begin
            check(tx_o[k] === 1'b1, $sformatf("reset tx dut%0d", k), int'(tx_o[k]), 1);
            check(busy_o[k] === 1'b0, $sformatf("reset busy dut%0d", k), int'(busy_o[k]), 0);
            check(done_o[k] === 1'b0, $sformatf("reset done dut%0d", k), int'(done_o[k]), 0);
        end
        rst     = 1'b0;
        tick_en = 1'b1;
        repeat (4) @(posedge clk);

        for (int i = 0; i < 10; i++) begin
            base = frames[vecs[i].dut];
            sb_q.push_back(vecs[i]);
            send(vecs[i].dut, vecs[i].din);
            wait_frames(vecs[i].dut, base + 1, $sformatf("vec%0d", i));
            repeat (8) @(posedge clk);
        end

        // Start request during DATA must be ignored.
        base = frames[0];
        d0   = dones[0];
        sb_q.push_back('{0, 8'h3C, 160, 1'b0});
        send(0, 8'h3C);
        repeat (200) @(posedge clk);
        #1;
        din      = 8'hFF;
        start[0] = 1'b1;
        @(posedge clk);
        #1;
        start[0] = 1'b0;
        wait_frames(0, base + 1, "collision");
        repeat (800) @(posedge clk);
        check(frames[0] == base + 1, "collision frame_count", frames[0] - base, 1);
        check(dones[0] - d0 == 1, "collision done_count", dones[0] - d0, 1);
        check(sb_q.size() == 0, "collision scoreboard_left", sb_q.size(), 0);

        // Start held high: two frames with exactly one idle clock between them.
        base = frames[0];
        d0   = dones[0];
        sb_q.push_back('{0, 8'h55, 160, 1'b0});
        sb_q.push_back('{0, 8'h55, 160, 1'b0});
        @(posedge clk);
        #1;
        din      = 8'h55;
        start[0] = 1'b1;
        cyc      = 0;
        while (cyc < 3000) begin
            @(negedge clk);
            cyc++;
            if (s_tick && done_o[0]) break;
        end
        gap     = 0;
        line_ok = 1'b1;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (busy_o[0]) break;
            gap++;
            if (tx_o[0] !== 1'b1) line_ok = 1'b0;
        end
        start[0] = 1'b0;
        check(gap == 1, "b2b idle_gap_clocks", gap, 1);
        check(line_ok, "b2b gap_line_high", int'(line_ok), 1);
        wait_frames(0, base + 2, "b2b");
        repeat (800) @(posedge clk);
        check(frames[0] == base + 2, "b2b frame_count", frames[0] - base, 2);
        check(dones[0] - d0 == 2, "b2b done_count", dones[0] - d0, 2);

        // Asynchronous abort during data bit 3, then a clean frame.
        sb_q.push_back('{0, 8'hA5, 160, 1'b0});
        send(0, 8'hA5);
        repeat (288) @(posedge clk);
        #1;
        check(tx_o[0] === 1'b0, "abort line_low_before_reset", int'(tx_o[0]), 0);
        rst = 1'b1;
        #1;
        check(tx_o[0] === 1'b1, "abort tx_async", int'(tx_o[0]), 1);
        check(busy_o[0] === 1'b0, "abort busy_async", int'(busy_o[0]), 0);
        sb_q.delete();
        repeat (3) @(negedge clk);
        rst  = 1'b0;
        base = frames[0];
        sb_q.push_back('{0, 8'hA5, 160, 1'b0});
        send(0, 8'hA5);
        wait_frames(0, base + 1, "after_abort");

        // Tick stall during START on the two-stop-bit instance.
        base = frames[3];
        sb_q.push_back('{3, 8'h96, 176, 1'b0});
        send(3, 8'h96);
        repeat (20) @(posedge clk);
        #1;
        tick_en = 1'b0;
        bad     = 0;
        for (int c = 0; c < 500; c++) begin
            @(negedge clk);
            if (tx_o[3] !== 1'b0 || busy_o[3] !== 1'b1) bad++;
        end
        check(bad == 0, "stall line_held_low_bad_clocks", bad, 0);
        @(posedge clk);
        #1;
        tick_en = 1'b1;
        wait_frames(3, base + 1, "stall");

        repeat (10) @(posedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
